// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder
// Holds one row of A and one column of B in two local operand buffers and,
// on command, streams a K-beat dot product into the FP32 PE. It then waits
// for the PE result, captures it, and reports completion.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en/wr_sel      buffer write strobe / select (0 = A, 1 = B)
//   wr_addr/wr_data   buffer write address / data
//   wr_err            one-cycle pulse: write dropped because busy
//   cmd_valid/ready   run request / accept (ready only in IDLE)
//   cmd_klen          dot-product length minus one
//   pause             suspend beat issue while streaming
//   pe_start          PE accumulator clear
//   pe_valid/pe_last  PE valid_in / last
//   pe_a/pe_b         PE operands
//   pe_c/pe_out_valid PE accumulated result / output_valid
//   busy, done        not idle / one-cycle completion pulse
//   result            captured PE result, held until the next capture
//   timeout_err       qualifies done: no PE result arrived in time
module pe_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_K      = 16,
  parameter int ADDR_W     = $clog2(MAX_K),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_klen,
  input  logic                  pause,
  output logic                  pe_start,
  output logic                  pe_valid,
  output logic                  pe_last,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_c,
  input  logic                  pe_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  timeout_err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] buf_a [MAX_K];
  logic [DATA_WIDTH-1:0] buf_b [MAX_K];

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] klen_q;
  logic [TO_W-1:0]   tmo_q;

  logic issue;
  logic last_beat;

  // Beat 0 is launched on the START edge so it lands two cycles after the
  // command; pause only applies to the STREAM edges that follow.
  assign issue     = (state_q == S_START) || ((state_q == S_STREAM) && !pause);
  assign last_beat = (idx_q == klen_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_START;
      S_START:  state_d = last_beat ? S_WAIT : S_STREAM;
      S_STREAM: if (!pause && last_beat) state_d = S_WAIT;
      // A PE result takes priority over a timeout on the same edge.
      S_WAIT:   if (pe_out_valid || (tmo_q == TO_LAST)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  // Buffers are deliberately outside reset so their contents survive an
  // abort and can be re-streamed by the next command.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) begin
        buf_b[wr_addr] <= wr_data;
      end else begin
        buf_a[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      klen_q      <= '0;
      tmo_q       <= '0;
      pe_start    <= 1'b0;
      pe_valid    <= 1'b0;
      pe_last     <= 1'b0;
      pe_a        <= '0;
      pe_b        <= '0;
      wr_err      <= 1'b0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      pe_start <= 1'b0;
      pe_valid <= 1'b0;
      pe_last  <= 1'b0;
      wr_err   <= wr_en && (state_q != S_IDLE);

      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            klen_q   <= cmd_klen;
            idx_q    <= '0;
            tmo_q    <= '0;
            pe_start <= 1'b1;
          end
        end
        S_START, S_STREAM: begin
          // pe_a/pe_b hold their last beat while paused.
          if (issue) begin
            pe_a     <= buf_a[idx_q];
            pe_b     <= buf_b[idx_q];
            pe_valid <= 1'b1;
            pe_last  <= last_beat;
            if (!last_beat) begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (pe_out_valid) begin
            result      <= pe_c;
            timeout_err <= 1'b0;
          end else if (tmo_q == TO_LAST) begin
            timeout_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed testbench for pe_operand_feeder: the PE is modelled by directly
// driving pe_c/pe_out_valid at chosen cycles.
module tb_pe_operand_feeder;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_K      = 16;
  localparam int ADDR_W     = $clog2(MAX_K);
  localparam int TIMEOUT    = 64;

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] JUNK = 32'h1234_5678;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_en;
  logic                  wr_sel;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_klen;
  logic                  pause;
  logic                  pe_start;
  logic                  pe_valid;
  logic                  pe_last;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [DATA_WIDTH-1:0] pe_c;
  logic                  pe_out_valid;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  timeout_err;

  logic [31:0] a_val [4];
  int n_checks;
  int n_pass;
  int cycles;

  pe_operand_feeder #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_K     (MAX_K),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_klen    (cmd_klen),
    .pause       (pause),
    .pe_start    (pe_start),
    .pe_valid    (pe_valid),
    .pe_last     (pe_last),
    .pe_a        (pe_a),
    .pe_b        (pe_b),
    .pe_c        (pe_c),
    .pe_out_valid(pe_out_valid),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: outputs read here belong to
  // the cycle following that edge, inputs set here are sampled at the next.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic sel, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] exp_a,
                           input logic exp_last);
    checkOutput({tag, "_valid"}, 32'(pe_valid), 32'd1);
    checkOutput({tag, "_a"},     pe_a,          exp_a);
    checkOutput({tag, "_b"},     pe_b,          ONE);
    checkOutput({tag, "_last"},  32'(pe_last),  32'(exp_last));
    checkOutput({tag, "_start"}, 32'(pe_start), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    a_val[0] = 32'h3F80_0000;
    a_val[1] = 32'h4000_0000;
    a_val[2] = 32'h4040_0000;
    a_val[3] = 32'h4080_0000;

    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_sel       = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    cmd_valid    = 1'b0;
    cmd_klen     = '0;
    pause        = 1'b0;
    pe_c         = JUNK;
    pe_out_valid = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_pe_valid", 32'(pe_valid), 32'd0);
    checkOutput("rst_pe_start", 32'(pe_start), 32'd0);
    checkOutput("rst_pe_a", pe_a, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // Load A = 1.0..4.0, B = 1.0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, ADDR_W'(i), a_val[i]);
      applyStimulus(1'b1, ADDR_W'(i), ONE);
    end
    checkOutput("idle_wr_err", 32'(wr_err), 32'd0);

    // Run 1: K=4, stray pe_out_valid during STREAM must be ignored
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(3);
    tick();
    cmd_valid = 1'b0;
    checkOutput("r1_start", 32'(pe_start), 32'd1);
    checkOutput("r1_busy", 32'(busy), 32'd1);
    checkOutput("r1_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("r1_valid_in_start", 32'(pe_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBeat($sformatf("r1_beat%0d", i), a_val[i], i == 3);
      checkOutput($sformatf("r1_done_b%0d", i), 32'(done), 32'd0);
      pe_out_valid = (i == 1);
      pe_c         = (i == 1) ? 32'hBADB_AD00 : JUNK;
    end
    tick();
    checkOutput("r1_valid_wait", 32'(pe_valid), 32'd0);
    checkOutput("r1_done_early", 32'(done), 32'd0);
    pe_out_valid = 1'b1;
    pe_c         = 32'h4120_0000;
    tick();
    pe_out_valid = 1'b0;
    pe_c         = JUNK;
    checkOutput("r1_done", 32'(done), 32'd1);
    checkOutput("r1_result", result, 32'h4120_0000);
    checkOutput("r1_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("r1_done_pulse", 32'(done), 32'd0);
    checkOutput("r1_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("r1_result_hold", result, 32'h4120_0000);

    // Run 2: K=1, pause held through START has no effect
    pause     = 1'b1;
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("r2_start", 32'(pe_start), 32'd1);
    tick();
    checkBeat("r2_beat0", a_val[0], 1'b1);
    pause = 1'b0;
    tick();
    checkOutput("r2_no_second_beat", 32'(pe_valid), 32'd0);
    checkOutput("r2_busy", 32'(busy), 32'd1);
    pe_out_valid = 1'b1;
    pe_c         = ONE;
    tick();
    pe_out_valid = 1'b0;
    pe_c         = JUNK;
    checkOutput("r2_done", 32'(done), 32'd1);
    checkOutput("r2_result", result, ONE);
    tick();

    // Run 3: K=4 with two pause cycles after beat 1
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(3);
    tick();
    cmd_valid = 1'b0;
    checkOutput("r3_start", 32'(pe_start), 32'd1);
    tick();
    checkBeat("r3_beat0", a_val[0], 1'b0);
    tick();
    checkBeat("r3_beat1", a_val[1], 1'b0);
    pause = 1'b1;
    tick();
    checkOutput("r3_pause1_valid", 32'(pe_valid), 32'd0);
    tick();
    checkOutput("r3_pause2_valid", 32'(pe_valid), 32'd0);
    checkOutput("r3_pause2_a_hold", pe_a, a_val[1]);
    pause = 1'b0;
    tick();
    checkBeat("r3_beat2", a_val[2], 1'b0);
    tick();
    checkBeat("r3_beat3", a_val[3], 1'b1);
    tick();
    checkOutput("r3_after_valid", 32'(pe_valid), 32'd0);
    pe_out_valid = 1'b1;
    pe_c         = 32'h4120_0000;
    tick();
    pe_out_valid = 1'b0;
    pe_c         = JUNK;
    checkOutput("r3_done", 32'(done), 32'd1);
    checkOutput("r3_result", result, 32'h4120_0000);
    tick();

    // Run 4: PE never answers -> timeout after TIMEOUT cycles in WAIT
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(0);
    tick();
    cmd_valid = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput("r4_cycles_to_done", 32'(cycles), 32'(TIMEOUT + 1));
    checkOutput("r4_done", 32'(done), 32'd1);
    checkOutput("r4_timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("r4_result_kept", result, 32'h4120_0000);
    tick();
    checkOutput("r4_done_pulse", 32'(done), 32'd0);

    // Run 5: cmd_valid held while busy, A write dropped during STREAM
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(3);
    tick();
    checkOutput("r5_start", 32'(pe_start), 32'd1);
    checkOutput("r5_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    checkBeat("r5_beat0", a_val[0], 1'b0);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = ADDR_W'(2);
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    checkOutput("r5_wr_err", 32'(wr_err), 32'd1);
    checkBeat("r5_beat1", a_val[1], 1'b0);
    tick();
    checkOutput("r5_wr_err_pulse", 32'(wr_err), 32'd0);
    checkBeat("r5_beat2", a_val[2], 1'b0);
    tick();
    checkBeat("r5_beat3", a_val[3], 1'b1);
    checkOutput("r5_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    cmd_valid    = 1'b0;
    pe_out_valid = 1'b1;
    pe_c         = 32'h4000_0000;
    tick();
    pe_out_valid = 1'b0;
    pe_c         = JUNK;
    checkOutput("r5_done", 32'(done), 32'd1);
    checkOutput("r5_result", result, 32'h4000_0000);
    checkOutput("r5_timeout_err_clr", 32'(timeout_err), 32'd0);
    tick();

    // Run 6: reset at beat 2, then write+command in the same IDLE cycle
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(3);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    checkBeat("r6_beat2", a_val[2], 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("r6_rst_valid", 32'(pe_valid), 32'd0);
    checkOutput("r6_rst_last", 32'(pe_last), 32'd0);
    checkOutput("r6_rst_a", pe_a, 32'd0);
    checkOutput("r6_rst_b", pe_b, 32'd0);
    checkOutput("r6_rst_busy", 32'(busy), 32'd0);
    checkOutput("r6_rst_done", 32'(done), 32'd0);
    checkOutput("r6_rst_result", result, 32'd0);
    checkOutput("r6_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    checkOutput("r6_no_done_1", 32'(done), 32'd0);
    tick();
    checkOutput("r6_no_done_2", 32'(done), 32'd0);
    a_val[3]  = 32'h40A0_0000;
    wr_en     = 1'b1;
    wr_sel    = 1'b0;
    wr_addr   = ADDR_W'(3);
    wr_data   = a_val[3];
    cmd_valid = 1'b1;
    cmd_klen  = ADDR_W'(3);
    tick();
    wr_en     = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("r6_start", 32'(pe_start), 32'd1);
    checkOutput("r6_wr_err", 32'(wr_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBeat($sformatf("r6_beat%0d", i), a_val[i], i == 3);
    end
    pe_out_valid = 1'b1;
    pe_c         = 32'h4130_0000;
    tick();
    pe_out_valid = 1'b0;
    pe_c         = JUNK;
    checkOutput("r6_done", 32'(done), 32'd1);
    checkOutput("r6_result", result, 32'h4130_0000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
